// File: rtl/wb_port_arbiter.sv
// Write-port arbiter for the register file: shares one write port between the
// in-order WB stage and a buffered long-latency (MUL/DIV) result stream.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid,
  input  logic            pipe_regwen,
  input  logic [4:0]      pipe_rd,
  input  logic [1:0]      pipe_WB_sel,
  output logic [1:0]      WB_sel,
  input  logic [XLEN-1:0] wb,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            pipe_stall,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_FIFO
  } grant_e;

  logic [4:0]      mem_rd_q   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic   pipe_use;
  logic   fifo_empty;
  logic   fifo_full;
  logic   starved;
  logic   push;
  logic   push_store;
  logic   pop;
  grant_e grant;

  assign WB_sel     = pipe_WB_sel;
  assign pipe_use   = pipe_valid & pipe_regwen & (pipe_rd != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign starved    = (starve_q == LIMIT_C);

  // Gated by rst_n so the unit never sees a handshake while the block is held in reset.
  assign lu_ready   = rst_n & ~fifo_full;
  assign push       = lu_valid & lu_ready;
  assign push_store = push & (lu_rd != 5'd0);

  // Port ownership; built only from registered FIFO state and pipe_use, never lu_valid.
  always_comb begin
    grant      = GRANT_NONE;
    pipe_stall = 1'b0;
    if (fifo_empty) begin
      if (pipe_use) grant = GRANT_PIPE;
    end else if (!pipe_use) begin
      grant = GRANT_FIFO;
    end else if (!starved) begin
      grant = GRANT_PIPE;
    end else begin
      grant      = GRANT_FIFO;
      pipe_stall = 1'b1;
    end
  end

  assign pop = (grant == GRANT_FIFO);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_store) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)        rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A non-empty FIFO that is not popped has lost the port to the pipeline this cycle.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    case (grant)
      GRANT_PIPE: begin
        rf_we_d    = 1'b1;
        rf_rd_d    = pipe_rd;
        rf_wdata_d = wb;
      end
      GRANT_FIFO: begin
        rf_we_d    = 1'b1;
        rf_rd_d    = mem_rd_q[rd_ptr_q];
        rf_wdata_d = mem_data_q[rd_ptr_q];
      end
      default: begin
        rf_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage is left unreset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_store) begin
      mem_rd_q[wr_ptr_q]   <= lu_rd;
      mem_data_q[wr_ptr_q] <= lu_data;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Owns the single register-file write port at the end of the RISC-V pipeline. It shares that port between the in-order WB stage and a long-latency execution unit (multi-cycle MUL/DIV) that returns results out of order. The block forwards WB_sel to the write-back mux and takes the mux result back in. It buffers long-latency results in a small FIFO, schedules port ownership, and stalls the pipeline when a buffered result would otherwise starve.

Parameters:
XLEN, 32, datapath width
DEPTH, 2, long-latency result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, max consecutive cycles a non-empty FIFO head may be denied the port

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pipe_valid  input  1  WB stage holds a valid instruction
pipe_regwen  input  1  WB instruction writes rd
pipe_rd  input  5  WB destination register
pipe_WB_sel  input  2  write-back source from decode (00 mem, 01 alu, 10 pc+4)
WB_sel  output  2  select driven to write-back mux
wb  input  XLEN  write-back mux result
lu_valid  input  1  long-latency unit offers a result
lu_ready  output  1  FIFO can accept the result
lu_rd  input  5  result destination register
lu_data  input  XLEN  result value
pipe_stall  output  1  hold WB stage and everything upstream this cycle
rf_we  output  1  register-file write enable (registered)
rf_rd  output  5  register-file write address (registered)
rf_wdata  output  XLEN  register-file write data (registered)

Behaviour:
- Reset: asynchronous, active-low. Clears FIFO pointers and count, starve_cnt, rf_we, rf_rd and rf_wdata to 0. While rst_n=0: lu_ready=0 and pipe_stall=0. Reset mid-operation discards all buffered results.
- WB_sel = pipe_WB_sel, combinational pass-through.
- pipe_use = pipe_valid & pipe_regwen & (pipe_rd != 0).
- lu_ready = (count < DEPTH), combinational from registered count. Push occurs when lu_valid & lu_ready. A push with lu_rd=0 is accepted and dropped, with no write and no count change.
- Pushed entries become eligible for pop the following cycle. There is no bypass.
- Grant, evaluated combinationally each cycle:
  - FIFO empty: the port goes to the pipeline if pipe_use.
  - FIFO non-empty and !pipe_use: pop the head to the port.
  - FIFO non-empty and pipe_use and starve_cnt < STARVE_LIMIT: the pipeline wins.
  - FIFO non-empty and pipe_use and starve_cnt == STARVE_LIMIT: pipe_stall=1 and the head is popped to the port. The WB instruction must still be presented the next cycle.
- Port registers, one-cycle latency:
  - On a pipeline grant: rf_we<=1, rf_rd<=pipe_rd, rf_wdata<=wb.
  - On a FIFO grant: rf_we<=1, rf_rd<=head rd, rf_wdata<=head data.
  - Otherwise: rf_we<=0, and rf_rd/rf_wdata hold.
- starve_cnt:
  - Reset to 0 on a pop or when the FIFO is empty.
  - Otherwise +1 each cycle the head is denied, saturating at STARVE_LIMIT.
- Simultaneous push and pop: both happen and count is unchanged. Push while full is impossible because lu_ready=0.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Minimum latency: WB result to rf write is 1 cycle. Long-latency result to rf write is 2 cycles.
- WAW/RAW ordering between the two sources is guaranteed by the issue scoreboard and is not checked here.
- pipe_stall depends only on registered state, pipe_use and FIFO status. It never depends on lu_valid, so there is no combinational loop with the unit.

Test Plan:
- Reset sequence: assert rst_n=0 mid-stream with FIFO holding 2 entries, then release. Required: rf_we=0, lu_ready=1, count=0, no stale write after release.
- Pipeline only: pipe_use with pipe_rd=5, pipe_WB_sel=01, wb=0x0000_1234. Required: WB_sel=01 same cycle, and next cycle rf_we=1, rf_rd=5, rf_wdata=0x0000_1234.
- Idle-port drain: lu push of rd=7, data=0xDEAD_BEEF with pipe idle. Required: rf write rd=7, data=0xDEAD_BEEF exactly 2 cycles after the push, with no stall.
- Starvation: one FIFO entry plus continuous pipe_use with STARVE_LIMIT=4. Required: 4 pipeline writes, then pipe_stall=1 for exactly one cycle, then the FIFO entry is written, then the held WB instruction is written the next cycle.
- Full backpressure: push 2 entries while pipe_use is continuous. Required: lu_ready=0 while count=2, returning to 1 the cycle after the forced pop.
- x0 handling: pipe_rd=0 with regwen=1 leaves the port free for the FIFO head that cycle. An lu push with lu_rd=0 produces no rf_we.
